// File: rtl/sift_pkg.sv
// sift_pkg: shared keypoint-memory geometry, stream set IDs and word field positions.
//   KP_DEPTH  entries per keypoint memory (counts clamp to this)
//   ADDR_W    keypoint memory address width
//   KP_W      keypoint word width, [18:10] row, [9:0] col
//   OUT_W     output stream word width
package sift_pkg;
    localparam int KP_DEPTH = 2000;
    localparam int ADDR_W = 11;
    localparam int KP_W = 19;
    localparam int OUT_W = 16;
    localparam logic [3:0] SET1_ID = 4'h1;
    localparam logic [3:0] SET2_ID = 4'h2;
    localparam int ROW_MSB = 18;
    localparam int ROW_LSB = 10;
    localparam int COL_MSB = 9;
    localparam int COL_LSB = 0;

    function automatic logic [ADDR_W-1:0] kp_clamp(input logic [ADDR_W-1:0] c);
        return (c > ADDR_W'(KP_DEPTH)) ? ADDR_W'(KP_DEPTH) : c;
    endfunction
endpackage

// File: rtl/keypoint_out_streamer_if.sv
// keypoint_out_streamer_if: valid/ready output stream of the keypoint streamer.
//   out_valid  out_data holds a word (master drives)
//   out_ready  sink accepts on out_valid && out_ready (slave drives)
//   out_data   16-bit stream word (master drives)
interface keypoint_out_streamer_if;
    import sift_pkg::*;
    logic out_valid;
    logic out_ready;
    logic [OUT_W-1:0] out_data;
    modport master(output out_valid, output out_data, input out_ready);
    modport slave(input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/keypoint_out_streamer.sv
// keypoint_out_streamer: serializes both keypoint memories into a headered 16-bit stream.
//   clk, rst             clock, asynchronous active-high reset
//   start                one-cycle pulse to begin a frame (ignored while busy)
//   kp1_count/kp2_count  entry counts, clamped and latched at start
//   kp_addr, kp_sel      shared read address, selected memory
//   kp1_dout/kp2_dout    memory read data, valid one cycle after the address
//   busy, done           frame in progress, one-cycle completion pulse
//   os                   valid/ready output stream
module keypoint_out_streamer
    import sift_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] kp1_count,
    input  logic [ADDR_W-1:0] kp2_count,
    output logic [ADDR_W-1:0] kp_addr,
    output logic              kp_sel,
    input  logic [KP_W-1:0]   kp1_dout,
    input  logic [KP_W-1:0]   kp2_dout,
    output logic              busy,
    output logic              done,
    keypoint_out_streamer_if.master os
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR1 = 3'd1;
    localparam logic [2:0] S_ROW  = 3'd2;
    localparam logic [2:0] S_COL  = 3'd3;
    localparam logic [2:0] S_HDR2 = 3'd4;
    localparam logic [2:0] S_FIN  = 3'd5;

    logic [2:0] state_q, state_d;
    logic [ADDR_W-1:0] n1_q, n1_d, n2_q, n2_d, idx_q, idx_d, kp_addr_q, kp_addr_d;
    logic kp_sel_q, kp_sel_d, out_valid_q, out_valid_d, busy_q, busy_d, done_q, done_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic [COL_MSB:COL_LSB] col_q, col_d;
    logic [KP_W-1:0] e2_q, e2_d, pend_q, pend_d;
    logic pend_vld_q, pend_vld_d, rd1_q, rd1_d, rd2_q, rd2_d;
    logic acc, go_row, go_hdr2, go_fin;
    logic [KP_W-1:0] dout_sel, row_src;
    logic [ADDR_W-1:0] n_cur, row_idx;

    assign acc = out_valid_q && os.out_ready;
    assign dout_sel = kp_sel_q ? kp2_dout : kp1_dout;
    assign n_cur = kp_sel_q ? n2_q : n1_q;

    // The address idles at 0, so entry 0 of both memories is already on dout
    // while HDR1 is presented; set 2's entry 0 is parked in e2 for later.
    // Entry i+1 is read when row i is loaded, which lands on dout while col i
    // is presented, keeping the stream gapless; stalls park it in pend.
    always_comb begin
        state_d = state_q;
        n1_d = n1_q;
        n2_d = n2_q;
        idx_d = idx_q;
        kp_addr_d = kp_addr_q;
        kp_sel_d = kp_sel_q;
        out_valid_d = out_valid_q;
        out_data_d = out_data_q;
        busy_d = busy_q;
        done_d = 1'b0;
        col_d = col_q;
        e2_d = e2_q;
        pend_d = pend_q;
        pend_vld_d = pend_vld_q;
        rd1_d = 1'b0;
        rd2_d = rd1_q;
        go_row = 1'b0;
        go_hdr2 = 1'b0;
        go_fin = 1'b0;
        row_idx = '0;
        row_src = '0;
        if (rd2_q) begin
            pend_d = dout_sel;
            pend_vld_d = 1'b1;
        end
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_HDR1;
                busy_d = 1'b1;
                kp_sel_d = 1'b0;
                n1_d = kp_clamp(kp1_count);
                n2_d = kp_clamp(kp2_count);
                out_valid_d = 1'b1;
                out_data_d = {SET1_ID, 1'b0, kp_clamp(kp1_count)};
            end
            S_HDR1: if (acc) begin
                e2_d = kp2_dout;
                go_row = n1_q != '0;
                go_hdr2 = n1_q == '0;
                row_src = kp1_dout;
            end
            S_ROW: if (acc) begin
                state_d = S_COL;
                out_data_d = {6'b0, col_q};
            end
            S_COL: if (acc) begin
                go_row = (idx_q + 11'd1) < n_cur;
                go_hdr2 = !go_row && !kp_sel_q;
                go_fin = !go_row && kp_sel_q;
                row_idx = idx_q + 11'd1;
                row_src = pend_vld_q ? pend_q : dout_sel;
            end
            S_HDR2: if (acc) begin
                go_row = n2_q != '0;
                go_fin = n2_q == '0;
                row_src = e2_q;
            end
            S_FIN: begin
                state_d = S_IDLE;
                busy_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
        if (go_row) begin
            state_d = S_ROW;
            idx_d = row_idx;
            col_d = row_src[COL_MSB:COL_LSB];
            out_data_d = {7'b0, row_src[ROW_MSB:ROW_LSB]};
            pend_vld_d = 1'b0;
            if ((row_idx + 11'd1) < n_cur) begin
                kp_addr_d = row_idx + 11'd1;
                rd1_d = 1'b1;
            end
        end
        if (go_hdr2) begin
            state_d = S_HDR2;
            kp_sel_d = 1'b1;
            out_data_d = {SET2_ID, 1'b0, n2_q};
        end
        if (go_fin) begin
            state_d = S_FIN;
            out_valid_d = 1'b0;
            done_d = 1'b1;
            kp_addr_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            n1_q <= '0;
            n2_q <= '0;
            idx_q <= '0;
            kp_addr_q <= '0;
            kp_sel_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            col_q <= '0;
            e2_q <= '0;
            pend_q <= '0;
            pend_vld_q <= 1'b0;
            rd1_q <= 1'b0;
            rd2_q <= 1'b0;
        end else begin
            state_q <= state_d;
            n1_q <= n1_d;
            n2_q <= n2_d;
            idx_q <= idx_d;
            kp_addr_q <= kp_addr_d;
            kp_sel_q <= kp_sel_d;
            out_valid_q <= out_valid_d;
            out_data_q <= out_data_d;
            busy_q <= busy_d;
            done_q <= done_d;
            col_q <= col_d;
            e2_q <= e2_d;
            pend_q <= pend_d;
            pend_vld_q <= pend_vld_d;
            rd1_q <= rd1_d;
            rd2_q <= rd2_d;
        end
    end

    assign kp_addr = kp_addr_q;
    assign kp_sel = kp_sel_q;
    assign busy = busy_q;
    assign done = done_q;
    assign os.out_valid = out_valid_q;
    assign os.out_data = out_data_q;
endmodule

// File: tb/tb_keypoint_out_streamer.sv
// tb_keypoint_out_streamer: scoreboard bench for the keypoint output streamer.
module tb_keypoint_out_streamer;
    import sift_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic out_ready = 1'b0;
    logic [ADDR_W-1:0] kp1_count = '0, kp2_count = '0, kp_addr;
    logic kp_sel, busy, done;
    logic [KP_W-1:0] kp1_dout, kp2_dout;
    logic [KP_W-1:0] mem1 [0:2047];
    logic [KP_W-1:0] mem2 [0:2047];

    keypoint_out_streamer_if os_if();
    assign os_if.out_ready = out_ready;

    keypoint_out_streamer dut (
        .clk(clk), .rst(rst), .start(start),
        .kp1_count(kp1_count), .kp2_count(kp2_count),
        .kp_addr(kp_addr), .kp_sel(kp_sel),
        .kp1_dout(kp1_dout), .kp2_dout(kp2_dout),
        .busy(busy), .done(done), .os(os_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        kp1_dout <= mem1[kp_addr];
        kp2_dout <= mem2[kp_addr];
    end

    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    int total = 0;
    int bad = 0;
    logic held = 1'b0;
    logic [15:0] held_data = '0;
    int max_a = 0;
    int max_a1 = 0;

    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held) begin
                total++;
                if (!(os_if.out_valid && os_if.out_data == held_data)) begin
                    bad++;
                    $display("FAIL stall_hold valid=%0b data=%h want valid=1 data=%h", os_if.out_valid, os_if.out_data, held_data);
                end
            end
            if (os_if.out_valid && out_ready) begin
                got_q.push_back(os_if.out_data);
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL stream_word got=%h want=<none>", os_if.out_data);
                end else if (exp_q[0] != os_if.out_data) begin
                    bad++;
                    $display("FAIL stream_word got=%h want=%h", os_if.out_data, exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
            end
            held = os_if.out_valid && !out_ready;
            held_data = os_if.out_data;
            if (busy) begin
                if (int'(kp_addr) > max_a) max_a = int'(kp_addr);
                if (!kp_sel && int'(kp_addr) > max_a1) max_a1 = int'(kp_addr);
            end
        end
    end

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic run_frame(input int c1, input int c2, input int n1, input int n2,
                             input logic [15:0] h1, input logic [15:0] h2,
                             input bit rnd, input int want_cyc);
        int cyc;
        logic [KP_W-1:0] w;
        exp_q.push_back(h1);
        for (int i = 0; i < n1; i++) begin
            w = mem1[i];
            exp_q.push_back({7'b0, w[18:10]});
            exp_q.push_back({6'b0, w[9:0]});
        end
        exp_q.push_back(h2);
        for (int i = 0; i < n2; i++) begin
            w = mem2[i];
            exp_q.push_back({7'b0, w[18:10]});
            exp_q.push_back({6'b0, w[9:0]});
        end
        got_q.delete();
        max_a = 0;
        max_a1 = 0;
        @(posedge clk); #1;
        kp1_count = 11'(c1);
        kp2_count = 11'(c2);
        start = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        chk("busy_after_start", int'(busy), 1);
        while (!done && cyc < 20000) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        chk("done_seen", int'(done), 1);
        if (want_cyc > 0) chk("done_cycle", cyc, want_cyc);
        chk("word_count", got_q.size(), 2 + 2 * (n1 + n2));
        chk("scoreboard_empty", exp_q.size(), 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("done_pulse", int'(done), 0);
        chk("busy_clear", int'(busy), 0);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) begin
            mem1[i] = {9'(i % 480), 10'((i * 7) % 640)};
            mem2[i] = {9'((i * 3) % 480), 10'((i + 100) % 640)};
        end
        mem1[0] = {9'd479, 10'd639};
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(os_if.out_valid), 0);
        chk("rst_out_data", int'(os_if.out_data), 0);
        chk("rst_kp_addr", int'(kp_addr), 0);
        chk("rst_kp_sel", int'(kp_sel), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        rst = 1'b0;

        run_frame(3, 2, 3, 2, 16'h1003, 16'h2002, 1'b0, 13);
        chk("first_word", int'(got_q[0]), 16'h1003);
        chk("e0_row_word", int'(got_q[1]), 16'h01DF);
        chk("e0_col_word", int'(got_q[2]), 16'h027F);
        chk("hdr2_word8", int'(got_q[7]), 16'h2002);

        run_frame(0, 0, 0, 0, 16'h1000, 16'h2000, 1'b0, 3);
        chk("empty_addr_static", max_a, 0);

        run_frame(40, 40, 40, 40, 16'h1028, 16'h2028, 1'b1, 0);

        run_frame(2047, 1, 2000, 1, 16'h17D0, 16'h2001, 1'b0, 4005);
        chk("clamp_last_addr1", max_a1, 1999);

        exp_q.push_back(16'h1005);
        exp_q.push_back({7'b0, 9'd479});
        exp_q.push_back({6'b0, 10'd639});
        @(posedge clk); #1;
        kp1_count = 11'd5;
        kp2_count = 11'd0;
        start = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("valid_before_rst", int'(os_if.out_valid), 1);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_valid", int'(os_if.out_valid), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_addr", int'(kp_addr), 0);
        chk("rst_partial_words", exp_q.size(), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        run_frame(2, 1, 2, 1, 16'h1002, 16'h2001, 1'b0, 9);
        chk("after_rst_hdr1", int'(got_q[0]), 16'h1002);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
